// File: rtl/matmul_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : matmul_seq_ctrl
// Description : Sequencer for C = A x B on one shared MAC unit; walks i/j/k
//               and drives operand reads, MAC strobes and C write-back.
// Revision    : 1.0 - initial release
// ============================================================================
module matmul_seq_ctrl #(
    parameter int N  = 2,
    parameter int IW = 1,
    parameter int AW = 2
) (
    input  logic          gclk,
    input  logic          rnot,
    input  logic          start,
    input  logic          stall,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] a_addr,
    output logic [AW-1:0] b_addr,
    output logic          mac_clr,
    output logic          mac_en,
    output logic          c_we,
    output logic [AW-1:0] c_addr
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CLR  = 3'd1;
    localparam logic [2:0] S_MAC  = 3'd2;
    localparam logic [2:0] S_WB   = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [IW-1:0] C_LAST = IW'(N - 1);
    localparam logic [IW-1:0] C_ZERO = IW'(0);
    localparam logic [IW-1:0] C_ONE  = IW'(1);

    logic [2:0]    r_state;
    logic [IW-1:0] r_i;
    logic [IW-1:0] r_j;
    logic [IW-1:0] r_k;
    logic          r_busy;
    logic          r_done;
    logic          r_mac_clr;
    logic          r_c_we;

    // Strobes are computed one edge ahead so each one is a flop output.
    always_ff @(posedge gclk) begin
        if (!rnot) begin
            r_state   <= S_IDLE;
            r_i       <= C_ZERO;
            r_j       <= C_ZERO;
            r_k       <= C_ZERO;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_mac_clr <= 1'b0;
            r_c_we    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state   <= S_CLR;
                        r_i       <= C_ZERO;
                        r_j       <= C_ZERO;
                        r_k       <= C_ZERO;
                        r_busy    <= 1'b1;
                        r_mac_clr <= 1'b1;
                    end
                end
                S_CLR: begin
                    r_state   <= S_MAC;
                    r_k       <= C_ZERO;
                    r_mac_clr <= 1'b0;
                end
                S_MAC: begin
                    if (!stall) begin
                        if (r_k == C_LAST) begin
                            r_k     <= C_ZERO;
                            r_state <= S_WB;
                            r_c_we  <= 1'b1;
                        end else begin
                            r_k <= r_k + C_ONE;
                        end
                    end
                end
                S_WB: begin
                    r_c_we <= 1'b0;
                    if ((r_i == C_LAST) && (r_j == C_LAST)) begin
                        r_state <= S_DONE;
                        r_i     <= C_ZERO;
                        r_j     <= C_ZERO;
                        r_done  <= 1'b1;
                    end else begin
                        r_state   <= S_CLR;
                        r_mac_clr <= 1'b1;
                        if (r_j == C_LAST) begin
                            r_j <= C_ZERO;
                            r_i <= r_i + C_ONE;
                        end else begin
                            r_j <= r_j + C_ONE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_i     <= C_ZERO;
                    r_j     <= C_ZERO;
                    r_k     <= C_ZERO;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_i       <= C_ZERO;
                    r_j       <= C_ZERO;
                    r_k       <= C_ZERO;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b0;
                    r_mac_clr <= 1'b0;
                    r_c_we    <= 1'b0;
                end
            endcase
        end
    end

    // Stall gates the accumulate in the same cycle it is seen.
    assign mac_en  = (r_state == S_MAC) & ~stall;
    assign busy    = r_busy;
    assign done    = r_done;
    assign mac_clr = r_mac_clr;
    assign c_we    = r_c_we;
    assign a_addr  = {r_i, r_k};
    assign b_addr  = {r_k, r_j};
    assign c_addr  = {r_i, r_j};

endmodule
`default_nettype wire

// File: tb/tb_matmul_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_matmul_seq_ctrl
// Description : Scoreboard bench for matmul_seq_ctrl with a timeline model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matmul_seq_ctrl;

    localparam int N  = 2;
    localparam int IW = 1;
    localparam int AW = 2;

    logic          gclk = 1'b0;
    logic          rnot;
    logic          start;
    logic          stall;
    logic          busy;
    logic          done;
    logic [AW-1:0] a_addr;
    logic [AW-1:0] b_addr;
    logic          mac_clr;
    logic          mac_en;
    logic          c_we;
    logic [AW-1:0] c_addr;

    matmul_seq_ctrl #(.N(N), .IW(IW), .AW(AW)) u_dut (
        .gclk    (gclk),
        .rnot    (rnot),
        .start   (start),
        .stall   (stall),
        .busy    (busy),
        .done    (done),
        .a_addr  (a_addr),
        .b_addr  (b_addr),
        .mac_clr (mac_clr),
        .mac_en  (mac_en),
        .c_we    (c_we),
        .c_addr  (c_addr)
    );

    always #5 gclk = ~gclk;

    typedef struct {
        bit busy;
        bit done;
        bit clr;
        bit en;
        bit we;
        bit chk_ab;
        bit chk_c;
        int a;
        int b;
        int c;
        bit stl;
    } exp_t;

    exp_t q[$];
    exp_t tl[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    function automatic exp_t idle_e();
        exp_t x;
        x        = '{default: 0};
        x.chk_ab = 1'b1;
        x.chk_c  = 1'b1;
        return x;
    endfunction

    // Expected per-cycle outputs of one whole run, laid out element by element.
    task automatic build(input int mode);
        exp_t x;
        int   m;
        int   nst;
        tl.delete();
        nst = 0;
        for (int e = 0; e < N * N; e++) begin
            x      = '{default: 0};
            x.busy = 1'b1;
            x.clr  = 1'b1;
            x.stl  = (mode == 2) ? 1'b1 : 1'($urandom_range(0, 1));
            tl.push_back(x);
            m = 0;
            while (m < N) begin
                x        = '{default: 0};
                x.busy   = 1'b1;
                x.chk_ab = 1'b1;
                x.a      = (e / N) * N + m;
                x.b      = m * N + (e % N);
                if (mode == 1)
                    x.stl = ($urandom_range(0, 3) == 0);
                else if (mode == 2)
                    x.stl = (e == 2 && m == 0 && nst < 3);
                else
                    x.stl = 1'b0;
                if (x.stl) nst++;
                x.en = !x.stl;
                if (!x.stl) m++;
                tl.push_back(x);
            end
            x       = '{default: 0};
            x.busy  = 1'b1;
            x.we    = 1'b1;
            x.chk_c = 1'b1;
            x.c     = e;
            x.stl   = (mode == 0) ? 1'b0 : 1'b1;
            tl.push_back(x);
        end
        x      = '{default: 0};
        x.busy = 1'b1;
        x.done = 1'b1;
        x.stl  = 1'($urandom_range(0, 1));
        tl.push_back(x);
    endtask

    // One cycle: expectation for the current cycle, inputs for the next edge.
    task automatic drive(input exp_t x, input bit st, input bit sv, input bit rn);
        @(posedge gclk);
        #1;
        rnot  = rn;
        start = st;
        stall = sv;
        q.push_back(x);
    endtask

    task automatic run(input int mode, input int abort_at);
        drive(idle_e(), 1'b1, 1'($urandom_range(0, 1)), 1'b1);
        build(mode);
        for (int t = 0; t < tl.size(); t++) begin
            if (t == abort_at) begin
                drive(tl[t], 1'b1, tl[t].stl, 1'b0);
                drive(idle_e(), 1'b0, 1'b0, 1'b1);
                return;
            end
            drive(tl[t], 1'($urandom_range(0, 1)), tl[t].stl, 1'b1);
        end
    endtask

    always @(negedge gclk) begin
        exp_t x;
        bit   ok;
        if (q.size() != 0) begin
            x  = q.pop_front();
            ok = (busy === x.busy) && (done === x.done) && (mac_clr === x.clr) &&
                 (mac_en === x.en) && (c_we === x.we);
            if (x.chk_ab) ok = ok && (a_addr === AW'(x.a)) && (b_addr === AW'(x.b));
            if (x.chk_c)  ok = ok && (c_addr === AW'(x.c));
            n_chk++;
            if (ok) n_pass++;
            else $display("FAIL cycle_outputs t=%0t got busy=%b done=%b clr=%b en=%b we=%b a=%0d b=%0d c=%0d expected busy=%b done=%b clr=%b en=%b we=%b a=%0d b=%0d c=%0d (ab_chk=%b c_chk=%b)",
                          $time, busy, done, mac_clr, mac_en, c_we, a_addr, b_addr, c_addr,
                          x.busy, x.done, x.clr, x.en, x.we, x.a, x.b, x.c, x.chk_ab, x.chk_c);
        end
    end

    initial begin
        rnot  = 1'b0;
        start = 1'b1;
        stall = 1'b0;
        @(posedge gclk);
        #1;
        // Second reset cycle with start high, then release with start low.
        q.push_back(idle_e());
        drive(idle_e(), 1'b0, 1'b0, 1'b1);
        drive(idle_e(), 1'b0, 1'b1, 1'b1);

        run(0, -1);
        drive(idle_e(), 1'b0, 1'b0, 1'b1);
        run(2, -1);
        drive(idle_e(), 1'b0, 1'b0, 1'b1);
        run(1, -1);
        run(1, -1);
        drive(idle_e(), 1'b0, 1'b0, 1'b1);
        run(0, 8);
        run(0, -1);
        drive(idle_e(), 1'b0, 1'b0, 1'b1);
        for (int r = 0; r < 6; r++) begin
            run(1, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1);
        end
        drive(idle_e(), 1'b0, 1'b0, 1'b1);
        drive(idle_e(), 1'b0, 1'b0, 1'b1);

        @(negedge gclk);
        #1;
        n_chk++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain remaining=%0d expected=0", q.size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
